// File: rtl/cma_adapt_ctrl_pkg.sv
// Shared types and defaults for the CMA adaptation controller.
// State encodings are fixed because o_state is read by software/debug.
package cma_adapt_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WARMUP = 3'd1,
      ST_COARSE = 3'd2,
      ST_FINE   = 3'd3,
      ST_DD     = 3'd4
   } state_e;

   localparam logic [15:0] MU_INIT_DEFAULT      = 16'h1000;
   localparam int          MU_MAX_SHIFT_DEFAULT = 4;

   // States in which the tap-update datapath is allowed to adapt.
   function automatic logic is_adapting(state_e s);
      return (s == ST_COARSE) || (s == ST_FINE) || (s == ST_DD);
   endfunction

endpackage

// File: rtl/cma_adapt_ctrl_if.sv
// Control/status bundle between the FFE adaptation datapath and the controller.
// i_valid is a one-cycle symbol strobe with no backpressure: every valid symbol
// not dropped by i_freeze is consumed in the cycle it is presented.
interface cma_adapt_ctrl_if #(
   parameter int NB    = 8,
   parameter int NB_MU = 16
);
   logic                i_enable;
   logic                i_freeze;
   logic                i_valid;
   logic [NB-1:0]       i_cma_error;
   logic [NB-2:0]       i_th_dd;
   logic [NB-2:0]       i_th_fb;
   logic [NB_MU-1:0]    o_mu;
   logic                o_update_en;
   logic                o_dd_mode;
   logic                o_locked;
   logic [NB-2:0]       o_err_energy;
   logic [2:0]          o_state;

   modport master (
      output i_enable, i_freeze, i_valid, i_cma_error, i_th_dd, i_th_fb,
      input  o_mu, o_update_en, o_dd_mode, o_locked, o_err_energy, o_state
   );

   modport slave (
      input  i_enable, i_freeze, i_valid, i_cma_error, i_th_dd, i_th_fb,
      output o_mu, o_update_en, o_dd_mode, o_locked, o_err_energy, o_state
   );
endinterface

// File: rtl/cma_adapt_ctrl_err_energy_acc.sv
// Windowed mean |error| over 2^LOG2_WIN accepted symbols.
// window_end and mean are combinational for the symbol that closes the window.
module cma_adapt_ctrl_err_energy_acc #(
   parameter int NB       = 8,
   parameter int LOG2_WIN = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            hold,
   input  logic            valid,
   input  logic [NB-1:0]   err,
   output logic            window_end,
   output logic [NB-2:0]   mean
);
   localparam int ACC_W = NB - 1 + LOG2_WIN;

   logic [NB-2:0]       mag;
   logic [LOG2_WIN-1:0] cnt;
   logic [ACC_W-1:0]    acc;
   logic [ACC_W-1:0]    sum;
   logic                take;

   // The most negative code has no positive twin; clamp it to full scale.
   always_comb begin
      mag = err[NB-2:0];
      if (err == {1'b1, {(NB-1){1'b0}}}) begin
         mag = '1;
      end else if (err[NB-1]) begin
         mag = (NB-1)'(-err);
      end
   end

   assign take       = valid && !hold;
   assign window_end = take && (cnt == '1);
   assign sum        = acc + ACC_W'(mag);
   assign mean       = (NB-1)'(sum >> LOG2_WIN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         acc <= '0;
      end else if (clr || window_end) begin
         cnt <= '0;
         acc <= '0;
      end else if (take) begin
         cnt <= cnt + LOG2_WIN'(1);
         acc <= sum;
      end
   end

endmodule

// File: rtl/cma_adapt_ctrl.sv
// Adaptation sequencer for the CMA FFE: warm-up, coarse/fine CMA, then DD
// tracking, with fallback to fine CMA when windowed error energy degrades.
module cma_adapt_ctrl
   import cma_adapt_ctrl_pkg::*;
#(
   parameter int               NB           = 8,
   parameter int               NB_MU        = 16,
   parameter int               FFE_LEN      = 21,
   parameter int               LOG2_WIN     = 8,
   parameter int               N_COARSE_WIN = 4,
   parameter logic [NB_MU-1:0] MU_INIT      = MU_INIT_DEFAULT,
   parameter int               MU_MAX_SHIFT = MU_MAX_SHIFT_DEFAULT
) (
   input logic             i_clock,
   input logic             i_reset,
   cma_adapt_ctrl_if.slave bus
);
   localparam int CNT_MAX = (FFE_LEN - 1 > N_COARSE_WIN) ? FFE_LEN - 1 : N_COARSE_WIN;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int SHIFT_W = $clog2(MU_MAX_SHIFT + 1);

   localparam logic [CNT_W-1:0]   WARM_LAST   = CNT_W'(FFE_LEN - 2);
   localparam logic [CNT_W-1:0]   COARSE_LAST = CNT_W'(N_COARSE_WIN - 1);
   localparam logic [SHIFT_W-1:0] SHIFT_MAX   = SHIFT_W'(MU_MAX_SHIFT);

   state_e             state, state_next;
   logic [SHIFT_W-1:0] shift, shift_next;
   logic [CNT_W-1:0]   phase_cnt, cnt_next;
   logic               locked_q, locked_next;
   logic [NB_MU-1:0]   mu_q, mu_next;
   logic               dd_q, upd_q;
   logic [NB-2:0]      energy_q;
   logic               adapting, acc_valid, acc_clr, window_end;
   logic [NB-2:0]      mean;

   assign adapting  = is_adapting(state);
   assign acc_valid = bus.i_valid && bus.i_enable && adapting;
   assign acc_clr   = (state_next != state);

   cma_adapt_ctrl_err_energy_acc #(
      .NB       (NB),
      .LOG2_WIN (LOG2_WIN)
   ) u_acc (
      .clk        (i_clock),
      .rst        (i_reset),
      .clr        (acc_clr),
      .hold       (bus.i_freeze),
      .valid      (acc_valid),
      .err        (bus.i_cma_error),
      .window_end (window_end),
      .mean       (mean)
   );

   // phase_cnt counts warm-up symbols in WARMUP and completed windows in COARSE.
   always_comb begin
      state_next  = state;
      shift_next  = shift;
      cnt_next    = phase_cnt;
      locked_next = locked_q;
      mu_next     = '0;
      if (!bus.i_enable) begin
         state_next  = ST_IDLE;
         locked_next = 1'b0;
      end else if (!bus.i_freeze) begin
         case (state)
            ST_IDLE: state_next = ST_WARMUP;
            ST_WARMUP: begin
               if (bus.i_valid) begin
                  if (phase_cnt == WARM_LAST) state_next = ST_COARSE;
                  else                        cnt_next   = phase_cnt + CNT_W'(1);
               end
            end
            ST_COARSE: begin
               if (window_end) begin
                  if (phase_cnt == COARSE_LAST) begin
                     state_next = ST_FINE;
                     shift_next = SHIFT_W'(1);
                  end else begin
                     cnt_next = phase_cnt + CNT_W'(1);
                  end
               end
            end
            ST_FINE: begin
               if (window_end) begin
                  if (mean < bus.i_th_dd)     state_next = ST_DD;
                  else if (shift < SHIFT_MAX) shift_next = shift + SHIFT_W'(1);
               end
            end
            ST_DD: begin
               if (window_end) begin
                  if (mean > bus.i_th_fb) begin
                     state_next  = ST_FINE;
                     shift_next  = SHIFT_W'(1);
                     locked_next = 1'b0;
                  end else begin
                     locked_next = 1'b1;
                  end
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
      if (state_next != state) cnt_next = '0;

      // mu follows the current state so the last old-state update uses old mu.
      case (state)
         ST_COARSE: mu_next = MU_INIT;
         ST_FINE:   mu_next = MU_INIT >> shift;
         ST_DD:     mu_next = MU_INIT >> MU_MAX_SHIFT;
         default:   mu_next = '0;
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state     <= ST_IDLE;
         shift     <= '0;
         phase_cnt <= '0;
         locked_q  <= 1'b0;
         mu_q      <= '0;
         dd_q      <= 1'b0;
         upd_q     <= 1'b0;
         energy_q  <= '0;
      end else begin
         state     <= state_next;
         shift     <= shift_next;
         phase_cnt <= cnt_next;
         locked_q  <= locked_next;
         upd_q     <= bus.i_valid && !bus.i_freeze && adapting;
         if (!(bus.i_freeze && bus.i_enable)) begin
            mu_q <= mu_next;
            dd_q <= (state == ST_DD);
         end
         if (window_end) energy_q <= mean;
      end
   end

   assign bus.o_mu         = mu_q;
   assign bus.o_update_en  = upd_q;
   assign bus.o_dd_mode    = dd_q;
   assign bus.o_locked     = locked_q;
   assign bus.o_err_energy = energy_q;
   assign bus.o_state      = state;

endmodule
